// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive stream, FIFO status and error-flag bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             rx;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [CNT_W-1:0] count;
    logic             frame_err;
    logic             overrun;
    logic             err_clr;
    logic             irq;

    modport slave (
        input  rx, rx_ready, err_clr,
        output rx_data, rx_valid, count, frame_err, overrun, irq
    );

    modport master (
        output rx, rx_ready, err_clr,
        input  rx_data, rx_valid, count, frame_err, overrun, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with byte FIFO, sticky error flags and level irq
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int DEPTH        = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    uart_rx_fifo_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    logic          r_rx_meta;
    logic          r_rxs;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          w_push_req;
    logic          w_frame_set;
    logic          r_push_pend;
    logic [7:0]    r_push_byte;

    logic [7:0]    r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_ovr_set;
    logic          r_frame_err;
    logic          r_overrun;
    logic          r_irq;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_meta   <= 1'b1;
            r_rxs       <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_push_pend <= 1'b0;
            r_push_byte <= '0;
        end else begin
            r_rx_meta   <= bus.rx;
            r_rxs       <= r_rx_meta;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_push_pend <= w_push_req;
            r_push_byte <= r_shift;
        end
    end

    // Counter restarts on every state change and every sample, so each
    // sample lands one full bit period after the previous one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push_req  = 1'b0;
        w_frame_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rxs) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_nxt = '0;
                    if (!r_rxs) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rxs, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rxs) begin
                        w_push_req  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_set = 1'b1;
                        w_state_nxt = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                w_cnt_nxt = '0;
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop     = !w_empty && bus.rx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign w_wr      = r_push_pend && (!w_full || w_pop);
    assign w_ovr_set = r_push_pend && w_full && !w_pop;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= r_push_byte;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_frame_err <= w_frame_set | (r_frame_err & ~bus.err_clr);
            r_overrun   <= w_ovr_set | (r_overrun & ~bus.err_clr);
            r_irq       <= !w_empty | r_frame_err | r_overrun;
        end
    end

    assign bus.rx_data   = r_mem[r_rptr[AW-1:0]];
    assign bus.rx_valid  = !w_empty;
    assign bus.count     = r_wptr - r_rptr;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.irq       = r_irq;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo against a frame-level FIFO model
module tb_uart_rx_fifo;
    localparam int CPB      = 16;
    localparam int DEPTH    = 4;
    localparam int H        = CPB / 2;
    localparam int PUSH_LAT = 3 + H + 9 * CPB + 1;
    localparam int FERR_LAT = 3 + H + 9 * CPB;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bif ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bif)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        int         due;
        bit         is_err;
        logic [7:0] b;
    } ev_t;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_fall = 0;
    int         rise_cyc = -1;
    bit         chk_en = 0;
    bit         prev_v = 0;
    logic [7:0] m_q [$];
    ev_t        ev_q [$];
    bit         m_fe = 0;
    bit         m_ov = 0;
    bit         m_irq = 0;
    logic [7:0] popped [$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame-level model: a byte appears PUSH_LAT edges after its start-bit edge.
    initial begin
        bit   irq_n;
        bit   fe_set;
        bit   ov_set;
        ev_t  e;
        forever begin
            @(posedge wb_clk_i);
            cyc++;
            if (wb_rst_i) begin
                m_q.delete();
                ev_q.delete();
                m_fe  = 0;
                m_ov  = 0;
                m_irq = 0;
            end else begin
                irq_n  = (m_q.size() != 0) | m_fe | m_ov;
                fe_set = 0;
                ov_set = 0;
                if (bif.rx_ready && m_q.size() != 0) void'(m_q.pop_front());
                if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
                    e = ev_q.pop_front();
                    if (e.is_err) fe_set = 1;
                    else if (m_q.size() < DEPTH) m_q.push_back(e.b);
                    else ov_set = 1;
                end
                m_fe  = fe_set | (m_fe & !bif.err_clr);
                m_ov  = ov_set | (m_ov & !bif.err_clr);
                m_irq = irq_n;
            end
        end
    end

    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (chk_en) begin
                check("rx_valid", int'(bif.rx_valid), int'(m_q.size() != 0));
                check("count", int'(bif.count), m_q.size());
                if (m_q.size() != 0) check("rx_data", int'(bif.rx_data), int'(m_q[0]));
                check("frame_err", int'(bif.frame_err), int'(m_fe));
                check("overrun", int'(bif.overrun), int'(m_ov));
                check("irq", int'(bif.irq), int'(m_irq));
                if (bif.rx_valid && !prev_v) rise_cyc = cyc;
                if (bif.rx_valid && bif.rx_ready) popped.push_back(bif.rx_data);
            end
            prev_v = bif.rx_valid;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        ev_t        e;
        bits = {stop, b, 1'b0};
        @(posedge wb_clk_i);
        #1;
        last_fall = cyc;
        e.b       = b;
        e.is_err  = !stop;
        e.due     = stop ? cyc + PUSH_LAT : cyc + FERR_LAT;
        ev_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            bif.rx = bits[i];
            idle((i == 9) ? CPB - 1 : CPB);
        end
    endtask

    task automatic pop_one();
        int k;
        k = 0;
        @(posedge wb_clk_i);
        #1;
        while (!bif.rx_valid && k < 400) begin
            @(posedge wb_clk_i);
            #1;
            k++;
        end
        if (!bif.rx_valid) begin
            check("pop_timeout", 0, 1);
        end else begin
            bif.rx_ready = 1'b1;
            idle(1);
            bif.rx_ready = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        bif.err_clr = 1'b1;
        idle(1);
        bif.err_clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, int'(bif.rx_valid), 0);
        check({tag, "_data"}, int'(bif.rx_data), 0);
        check({tag, "_count"}, int'(bif.count), 0);
        check({tag, "_ferr"}, int'(bif.frame_err), 0);
        check({tag, "_ovr"}, int'(bif.overrun), 0);
        check({tag, "_irq"}, int'(bif.irq), 0);
    endtask

    initial begin
        bif.rx       = 1'b1;
        bif.rx_ready = 1'b0;
        bif.err_clr  = 1'b0;
        wb_rst_i     = 1'b1;
        idle(3);
        wb_rst_i = 1'b0;
        chk_en   = 1;
        check_reset_vals("reset");

        // single byte, rx_ready low
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("single_rise", rise_cyc, last_fall + PUSH_LAT);
        check("single_data", int'(bif.rx_data), 8'hA5);
        check("single_count", int'(bif.count), 1);
        check("single_irq", int'(bif.irq), 1);
        pop_one();
        check("single_pop_valid", int'(bif.rx_valid), 0);
        check("single_pop_count", int'(bif.count), 0);

        // back-to-back stream with consumer always ready
        popped.delete();
        bif.rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(8'(i), 1'b1);
        idle(170);
        bif.rx_ready = 1'b0;
        check("b2b_n", popped.size(), 3);
        for (int i = 0; i < 3; i++) check("b2b_data", int'(popped[i]), i);
        check("b2b_ferr", int'(bif.frame_err), 0);
        check("b2b_ovr", int'(bif.overrun), 0);

        // glitch shorter than half a bit
        @(posedge wb_clk_i);
        #1;
        bif.rx = 1'b0;
        idle(5);
        bif.rx = 1'b1;
        idle(30);
        check("glitch_count", int'(bif.count), 0);
        check("glitch_ferr", int'(bif.frame_err), 0);
        popped.delete();
        send_frame(8'h3C, 1'b1);
        idle(4);
        pop_one();
        check("glitch_next", int'(popped[0]), 8'h3C);

        // framing error followed by a held-low line
        send_frame(8'h55, 1'b0);
        idle(40);
        bif.rx = 1'b1;
        idle(20);
        check("ferr_set", int'(bif.frame_err), 1);
        check("ferr_count", int'(bif.count), 0);
        popped.delete();
        send_frame(8'h81, 1'b1);
        idle(4);
        pop_one();
        check("ferr_next", int'(popped[0]), 8'h81);
        pulse_clr();
        check("ferr_clr", int'(bif.frame_err), 0);

        // overrun with no consumer
        popped.delete();
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
        idle(4);
        check("ovr_count", int'(bif.count), 4);
        check("ovr_set", int'(bif.overrun), 1);
        for (int i = 0; i < 4; i++) pop_one();
        check("ovr_n", popped.size(), 4);
        for (int i = 0; i < 4; i++) check("ovr_data", int'(popped[i]), 8'h10 + i);
        pulse_clr();
        check("ovr_clr", int'(bif.overrun), 0);

        // pop coinciding with a push into a full FIFO
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        fork
            send_frame(8'h14, 1'b1);
            begin
                @(posedge wb_clk_i);
                repeat (PUSH_LAT - 1) @(posedge wb_clk_i);
                #1;
                bif.rx_ready = 1'b1;
                @(posedge wb_clk_i);
                #1;
                bif.rx_ready = 1'b0;
            end
        join
        idle(4);
        check("coinc_ovr", int'(bif.overrun), 0);
        check("coinc_count", int'(bif.count), 4);
        popped.delete();
        for (int i = 0; i < 4; i++) pop_one();
        check("coinc_head", int'(popped[0]), 8'h11);
        check("coinc_last", int'(popped[3]), 8'h14);

        // reset in the middle of a frame with flags and data pending
        send_frame(8'h00, 1'b0);
        idle(20);
        bif.rx = 1'b1;
        idle(20);
        send_frame(8'h77, 1'b1);
        idle(4);
        check("prerst_count", int'(bif.count), 1);
        check("prerst_ferr", int'(bif.frame_err), 1);
        @(posedge wb_clk_i);
        #1;
        bif.rx = 1'b0;
        idle(CPB);
        bif.rx = 1'b1;
        idle(4 * CPB + H);
        wb_rst_i = 1'b1;
        idle(1);
        wb_rst_i = 1'b0;
        check_reset_vals("midrst");
        idle(100);
        popped.delete();
        send_frame(8'h42, 1'b1);
        idle(4);
        pop_one();
        check("postrst_data", int'(popped[0]), 8'h42);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

User-project UART receiver with byte FIFO. It is the device-side end of the serial link that the testbench UART drives on `mprj_io[5]`. It oversamples the line with a clock-count divider, frames 8N1 characters, and queues received bytes in a small FIFO. Firmware or a Wishbone wrapper drains the FIFO through a valid/ready handshake and sees framing and overrun errors as sticky flags plus a level interrupt.

## Interface
- `CLKS_PER_BIT`, 4167: `wb_clk_i` cycles per bit (40 MHz / 9600). Must be ≥ 4.
- `DEPTH`, 4: FIFO entries. Power of two, ≥ 2.
- `wb_clk_i` input 1: single clock. All logic is on its rising edge.
- `wb_rst_i` input 1: synchronous, active-high reset.
- `rx` input 1: serial line, asynchronous, idle high.
- `rx_data` output 8: byte at FIFO head. Valid only while `rx_valid` is high.
- `rx_valid` output 1: FIFO not empty.
- `rx_ready` input 1: consumer accepts the head byte. A pop occurs on `rx_valid && rx_ready`.
- `count` output $clog2(DEPTH)+1: current FIFO occupancy.
- `frame_err` output 1: sticky flag. Set when a stop bit is sampled as 0.
- `overrun` output 1: sticky flag. Set when a byte completes while the FIFO is full.
- `err_clr` input 1: one-cycle pulse that clears `frame_err` and `overrun`.
- `irq` output 1: `rx_valid | frame_err | overrun`, registered.

## Operation
- **Synchronizer:** `rx` passes through a two-flop synchronizer (reset value 1). All FSM decisions use the synchronized value `rxs`.
- **Bit counter:** 
  - Width is $clog2(CLKS_PER_BIT).
  - `H = CLKS_PER_BIT/2` (integer division).
  - Counter reloads to 0 on every state change and on each sample.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE: `rxs==0` → START. This cycle is t0.
  - START: at count H-1, sample `rxs`. If 0 → DATA with bit index 0. If 1 → IDLE (glitch rejected, nothing pushed).
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into a shift register, LSB first. After the 8th bit → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - 1: push the byte to the FIFO → IDLE.
    - 0: set `frame_err`, discard the byte → WAIT_HI.
  - WAIT_HI: stay until `rxs==1` → IDLE. This prevents a break condition from re-triggering.
- **FIFO:** circular buffer with read/write pointers one bit wider than the index. Full = MSBs differ and index bits are equal.
  - Push when full: byte dropped, `overrun` set, contents unchanged.
  - Push and pop in the same cycle when full: pop frees an entry and the push is accepted. No overrun; `count` unchanged.
  - Pop while empty cannot occur (gated by `rx_valid`).
- **Error flags:**
  - `err_clr` in the same cycle as a new error: the set wins.
  - `err_clr` does not affect FIFO contents.

## Timing
- **Reset values:** `rx_valid=0`, `rx_data=0`, `count=0`, `frame_err=0`, `overrun=0`, `irq=0`. FSM in IDLE, synchronizer at 1.
- **Reset mid-frame:** the partial byte is discarded, the FIFO is emptied, and the flags are cleared. After reset release, a line held low is treated as a new start edge.
- **Pin to t0:** 2 cycles from the `rx` falling edge (synchronizer delay).
- **Sample points:**
  - Start bit at t0+H.
  - Data bit i at t0+H+(i+1)·CLKS_PER_BIT.
  - Stop bit at t0+H+9·CLKS_PER_BIT.
- **Push timing:** the push takes effect at the stop-sample edge. `rx_valid`, `rx_data` and `count` update one cycle later; `irq` one further cycle.
- **Back-to-back frames:** a start bit immediately following a stop bit is detected. The FSM returns to IDLE within one cycle of the stop sample, which leaves about 0.5 bit of margin.
- **Pop:** on the edge where `rx_valid && rx_ready`, the read pointer advances. The next head appears on `rx_data` in the following cycle, with no bubble.
- **Tolerance:** sampling at bit center tolerates ±4% baud mismatch over a frame.

## Test plan
Use `CLKS_PER_BIT=16` and `DEPTH=4`.
- **Single byte:** send 0xA5 8N1 with `rx_ready=0` → `rx_valid` rises at t0+H+9·16+1, `rx_data=0xA5`, `count=1`, `irq=1`. Assert `rx_ready` for one cycle → `rx_valid=0`, `count=0`.
- **Back-to-back stream:** send 0x00, 0x01, 0x02 with no idle gap and `rx_ready=1` → three pops in order, data 0x00/0x01/0x02, no errors.
- **Glitch rejection:** drive `rx` low for 5 cycles (< H), then high → FSM returns to IDLE, `count=0`, no flags. A following 0x3C frame is received correctly.
- **Framing error:** send 0x55 with stop bit = 0, then hold `rx` low for 40 cycles → `frame_err=1`, `count=0`, FSM stays in WAIT_HI. After `rx` rises, a 0x81 frame is received. Pulse `err_clr` → `frame_err=0`.
- **Overrun:** send 5 bytes 0x10–0x14 with `rx_ready=0` → `count=4`, `overrun=1`, and pops return 0x10..0x13. Separately, fill the FIFO and time `rx_ready` so the pop coincides with the 5th push → no overrun, and 0x14 is retained.
- **Reset mid-frame:** assert `wb_rst_i` for one cycle during DATA bit 4 of 0xFF → all outputs at reset values. A subsequent clean 0x42 frame is received as 0x42.
